edge_bitmap_builder: RTL and testbench

- Streaming edge-detection stage that sits directly upstream of the VGA display block.
- Accepts a raster-order grayscale pixel stream and computes a per-pixel gradient (left and above neighbours) using one line buffer.
- Thresholds each gradient into one edge bit and assembles a WIDTH*DEPTH edge bitmap.
- Hands the complete bitmap to the display with a valid/ack handshake; bit index y*WIDTH+x, 1 = edge.

---
 rtl/edge_bitmap_builder.sv | 123 ++++++++++++
 tb/tb_edge_bitmap_builder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_bitmap_builder.sv
// Streaming edge detector: gradient against the left and above neighbours, thresholded into a WIDTH*DEPTH bitmap.
// Define EDGE_DIAG_EN to add an up-left diagonal term to the gradient sum.
module edge_bitmap_builder #(
   parameter int WIDTH  = 9,
   parameter int DEPTH  = 9,
   parameter int PIX_W  = 8,
   parameter int THRESH = 32
) (
   input  logic                   dclk,
   input  logic                   clr,
   input  logic [PIX_W-1:0]       pix_in,
   input  logic                   pix_valid,
   input  logic                   pix_sof,
   output logic                   pix_ready,
   output logic [WIDTH*DEPTH-1:0] bitmap,
   output logic                   bitmap_valid,
   input  logic                   bitmap_ack,
   output logic                   frame_err
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(DEPTH);
   localparam int IW = $clog2(WIDTH * DEPTH);
`ifdef EDGE_DIAG_EN
   localparam int SUM_W = PIX_W + 2;
`else
   localparam int SUM_W = PIX_W + 1;
`endif

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state, state_next;
   logic [XW-1:0]    x, ex;
   logic [YW-1:0]    y, ey;
   logic [PIX_W-1:0] linebuf [WIDTH];
   logic [PIX_W-1:0] left_reg;
   logic [PIX_W-1:0] left_pix, above_pix;
   logic [SUM_W-1:0] sum;
   logic [IW-1:0]    idx;
   logic             accept, edge_bit, last_pix, mid_frame;
`ifdef EDGE_DIAG_EN
   logic [PIX_W-1:0] upleft_reg;
   logic [PIX_W-1:0] upleft_pix;
`endif

   function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   assign pix_ready    = (state == ACCUM);
   assign bitmap_valid = (state == HOLD);
   assign accept       = pix_valid && pix_ready;

   // A start-of-frame pixel is always treated as position (0,0), whatever the counters say.
   assign ex        = pix_sof ? '0 : x;
   assign ey        = pix_sof ? '0 : y;
   assign mid_frame = (x != '0) || (y != '0);
   assign last_pix  = (ex == XW'(WIDTH - 1)) && (ey == YW'(DEPTH - 1));
   assign idx       = IW'(int'(ey) * WIDTH + int'(ex));

   assign left_pix  = (ex == '0) ? pix_in : left_reg;
   assign above_pix = (ey == '0) ? pix_in : linebuf[ex];

`ifdef EDGE_DIAG_EN
   // upleft_reg holds linebuf[x-1] as read on the previous accept, i.e. before that accept's write.
   assign upleft_pix = (ex == '0 || ey == '0) ? pix_in : upleft_reg;
   assign sum = SUM_W'(absdiff(pix_in, left_pix)) + SUM_W'(absdiff(pix_in, above_pix))
              + SUM_W'(absdiff(pix_in, upleft_pix));
`else
   assign sum = SUM_W'(absdiff(pix_in, left_pix)) + SUM_W'(absdiff(pix_in, above_pix));
`endif

   assign edge_bit = (sum > SUM_W'(THRESH));

   always_comb begin
      state_next = state;
      case (state)
         ACCUM: if (accept && last_pix) state_next = HOLD;
         HOLD:  if (bitmap_ack)         state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge dclk) begin
      if (clr) begin
         state     <= ACCUM;
         x         <= '0;
         y         <= '0;
         left_reg  <= '0;
         bitmap    <= '0;
         frame_err <= 1'b0;
         // NOTE: the line buffer is a small register file, so it is cleared explicitly rather than left undefined.
         for (int i = 0; i < WIDTH; i++) linebuf[i] <= '0;
`ifdef EDGE_DIAG_EN
         upleft_reg <= '0;
`endif
      end else begin
         state <= state_next;
         if (accept) begin
            linebuf[ex] <= pix_in;
            left_reg    <= pix_in;
`ifdef EDGE_DIAG_EN
            upleft_reg  <= linebuf[ex];
`endif
            // A restart discards the partial frame; the later write to bit 0 wins over the clear.
            if (pix_sof && mid_frame) begin
               bitmap    <= '0;
               frame_err <= 1'b1;
            end
            bitmap[idx] <= edge_bit;
            if (ex == XW'(WIDTH - 1)) begin
               x <= '0;
               y <= (ey == YW'(DEPTH - 1)) ? '0 : ey + YW'(1);
            end else begin
               x <= ex + XW'(1);
               y <= ey;
            end
         end
      end
   end

endmodule

// File: tb/tb_edge_bitmap_builder.sv
// Self-checking bench for edge_bitmap_builder: step-pattern table, handshake/restart/reset sequences, random frames.
module tb_edge_bitmap_builder;

   localparam int W = 9;
   localparam int D = 9;
   localparam int N = W * D;
   localparam int TH = 32;

   logic         dclk = 1'b0;
   logic         clr = 1'b1;
   logic [7:0]   pix_in = '0;
   logic         pix_valid = 1'b0;
   logic         pix_sof = 1'b0;
   logic         pix_ready;
   logic [N-1:0] bitmap;
   logic         bitmap_valid;
   logic         bitmap_ack = 1'b0;
   logic         frame_err;

   int tests = 0;
   int fails = 0;

   logic [7:0] fr [D][W];

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      int         col;
      logic       edges;
   } step_vec_t;

   step_vec_t vecs [7];

   edge_bitmap_builder #(.WIDTH(W), .DEPTH(D), .PIX_W(8), .THRESH(TH)) dut (
      .dclk(dclk), .clr(clr), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .pix_ready(pix_ready), .bitmap(bitmap), .bitmap_valid(bitmap_valid),
      .bitmap_ack(bitmap_ack), .frame_err(frame_err)
   );

   always #5 dclk = ~dclk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference: edge map computed directly from the stored frame image.
   function automatic logic [N-1:0] model_bitmap();
      logic [N-1:0] m = '0;
      for (int yy = 0; yy < D; yy++)
         for (int xx = 0; xx < W; xx++) begin
            int p = fr[yy][xx];
            int l = (xx == 0) ? p : fr[yy][xx-1];
            int a = (yy == 0) ? p : fr[yy-1][xx];
            int s = iabs(p - l) + iabs(p - a);
`ifdef EDGE_DIAG_EN
            int u = (xx == 0 || yy == 0) ? p : fr[yy-1][xx-1];
            s += iabs(p - u);
`endif
            m[yy*W + xx] = (s > TH);
         end
      return m;
   endfunction

   function automatic logic [N-1:0] col_mask(input int col);
      logic [N-1:0] m = '0;
      for (int yy = 0; yy < D; yy++) m[yy*W + col] = 1'b1;
      return m;
   endfunction

   task automatic send_pixel(input logic [7:0] p, input logic s, input bit gaps);
      int   budget = 0;
      logic acc = 1'b0;
      if (gaps)
         while ($urandom_range(0, 3) == 0) begin
            pix_valid  = 1'b0;
            pix_sof    = 1'($urandom_range(0, 1));
            pix_in     = 8'($urandom);
            bitmap_ack = 1'($urandom_range(0, 1));
            @(posedge dclk); #1;
         end
      bitmap_ack = 1'b0;
      pix_in = p; pix_valid = 1'b1; pix_sof = s;
      while (!acc && budget < 200) begin
         acc = pix_ready;
         @(posedge dclk); #1;
         budget++;
      end
      if (!acc) check("accept_timeout", 0, 1);
      pix_valid = 1'b0; pix_sof = 1'b0;
   endtask

   // Sends pixels start..N-1 of fr; index 0 carries pix_sof.
   task automatic send_frame(input int start, input bit gaps);
      for (int i = start; i < N; i++) begin
         send_pixel(fr[i / W][i % W], i == 0, gaps);
         if (i == N - 2) check("valid_before_last", bitmap_valid, 0);
      end
      check("valid_latency", bitmap_valid, 1);
      check("ready_in_hold", pix_ready, 0);
      check("bitmap_model", bitmap, model_bitmap());
   endtask

   task automatic do_ack();
      bitmap_ack = 1'b1;
      @(posedge dclk); #1;
      bitmap_ack = 1'b0;
      check("ack_valid_low", bitmap_valid, 0);
      check("ack_ready_high", pix_ready, 1);
   endtask

   task automatic fill_uniform(input logic [7:0] v);
      for (int yy = 0; yy < D; yy++) for (int xx = 0; xx < W; xx++) fr[yy][xx] = v;
   endtask

   initial begin
      logic [N-1:0] held;

      vecs[0] = '{lo: 8'd100, hi: 8'd100, col: 4, edges: 1'b0};
      vecs[1] = '{lo: 8'd0,   hi: 8'd200, col: 4, edges: 1'b1};
      vecs[2] = '{lo: 8'd0,   hi: 8'd32,  col: 4, edges: 1'b0};
      vecs[3] = '{lo: 8'd0,   hi: 8'd33,  col: 4, edges: 1'b1};
      vecs[4] = '{lo: 8'd200, hi: 8'd0,   col: 6, edges: 1'b1};
      vecs[5] = '{lo: 8'd50,  hi: 8'd82,  col: 1, edges: 1'b0};
      vecs[6] = '{lo: 8'd50,  hi: 8'd83,  col: 8, edges: 1'b1};

      repeat (2) @(posedge dclk);
      #1 clr = 1'b0;
      check("rst_ready", pix_ready, 1);
      check("rst_valid", bitmap_valid, 0);
      check("rst_bitmap", bitmap, 0);
      check("rst_err", frame_err, 0);

      // Vertical-step table; first entry is the uniform frame with continuous pix_valid.
      for (int v = 0; v < 7; v++) begin
         for (int yy = 0; yy < D; yy++)
            for (int xx = 0; xx < W; xx++) fr[yy][xx] = (xx < vecs[v].col) ? vecs[v].lo : vecs[v].hi;
         send_frame(0, 0);
`ifndef EDGE_DIAG_EN
         check($sformatf("step_table_%0d", v), bitmap, vecs[v].edges ? col_mask(vecs[v].col) : '0);
`endif
         do_ack();
      end
      check("sof_at_origin_no_err", frame_err, 0);

      // HOLD: stalled consumer, producer keeps offering pixels (with sof) for 10 cycles.
      for (int yy = 0; yy < D; yy++) for (int xx = 0; xx < W; xx++) fr[yy][xx] = 8'((xx * 37 + yy * 91) % 256);
      send_frame(0, 0);
      held = bitmap;
      pix_in = 8'd255; pix_valid = 1'b1; pix_sof = 1'b1;
      repeat (10) @(posedge dclk);
      #1;
      check("hold_ready", pix_ready, 0);
      check("hold_valid", bitmap_valid, 1);
      check("hold_stable", bitmap, held);
      check("hold_no_err", frame_err, 0);
      bitmap_ack = 1'b1;
      @(posedge dclk); #1;
      bitmap_ack = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
      check("hold_ack_valid", bitmap_valid, 0);
      check("hold_ack_ready", pix_ready, 1);
      fill_uniform(8'd10);
      send_frame(0, 0);
      do_ack();

      // Random frames with idle gaps, spurious sof/ack while idle.
      for (int f = 0; f < 6; f++) begin
         for (int yy = 0; yy < D; yy++)
            for (int xx = 0; xx < W; xx++) fr[yy][xx] = 8'($urandom_range(0, 3) * 20 + $urandom_range(0, 15));
         send_frame(0, 1);
         repeat ($urandom_range(0, 3)) @(posedge dclk);
         #1 check("rand_hold_valid", bitmap_valid, 1);
         do_ack();
      end

      // Restart at pixel 40.
      for (int yy = 0; yy < D; yy++) for (int xx = 0; xx < W; xx++) fr[yy][xx] = 8'($urandom);
      for (int i = 0; i < 40; i++) send_pixel(fr[i / W][i % W], i == 0, 0);
      check("pre_restart_err", frame_err, 0);
      for (int yy = 0; yy < D; yy++) for (int xx = 0; xx < W; xx++) fr[yy][xx] = 8'($urandom);
      send_pixel(fr[0][0], 1'b1, 0);
      check("restart_err", frame_err, 1);
      check("restart_cleared", bitmap, 0);
      check("restart_valid", bitmap_valid, 0);
      send_frame(1, 0);
      check("err_sticky", frame_err, 1);
      do_ack();

      // clr mid-frame at pixel 50, with a pixel offered during clr.
      for (int i = 0; i < 50; i++) send_pixel(fr[i / W][i % W], i == 0, 0);
      pix_in = 8'd200; pix_valid = 1'b1; clr = 1'b1;
      @(posedge dclk); #1;
      clr = 1'b0; pix_valid = 1'b0;
      check("clr_err", frame_err, 0);
      check("clr_bitmap", bitmap, 0);
      check("clr_ready", pix_ready, 1);
      fill_uniform(8'd77);
      send_frame(0, 0);
      check("clr_frame_bitmap", bitmap, 0);
      check("clr_frame_err", frame_err, 0);

      // clr while in HOLD.
      clr = 1'b1;
      @(posedge dclk); #1;
      clr = 1'b0;
      check("clr_hold_valid", bitmap_valid, 0);
      check("clr_hold_ready", pix_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
